// File: rtl/gpio_mmio_responder_if.sv
// rtl/gpio_mmio_responder_if.sv - CPU load/store bus bundle for the GPIO responder
// Purpose: groups the load/store request and response signals of one bus port.
// Signals:
//   mem_read_en, mem_write_en  request strobes (one cycle each)
//   load_type, store_type      RV32 funct3 of the access
//   ram_address, data_in       byte address and right-aligned store data
//   data_out, data_valid       registered load result and its one-cycle strobe
//   access_fault               one-cycle strobe for a rejected selected access
// Modports: master = CPU side, slave = responder side.
interface gpio_mmio_responder_if;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [2:0]  load_type;
   logic [2:0]  store_type;
   logic [31:0] ram_address;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic        data_valid;
   logic        access_fault;

   modport master (
      output mem_read_en, mem_write_en, load_type, store_type, ram_address, data_in,
      input  data_out, data_valid, access_fault
   );

   modport slave (
      input  mem_read_en, mem_write_en, load_type, store_type, ram_address, data_in,
      output data_out, data_valid, access_fault
   );
endinterface

// File: rtl/gpio_mmio_responder.sv
// rtl/gpio_mmio_responder.sv - memory-mapped GPIO responder with edge interrupts
// Purpose: decodes byte/half/word loads and stores into the OUT, DIR, IN, IE, IS,
// POL and BOTH registers, synchronizes the pins and raises a level interrupt.
// Ports:
//   clk       core clock, rising edge
//   reset     asynchronous active-low reset
//   bus       load/store bus, slave side (request in, registered response out)
//   gpio_in   raw asynchronous pin inputs
//   gpio_out  OUT register
//   gpio_oe   DIR register (1 = drive)
//   gpio_irq  level interrupt, |(IS & IE)
module gpio_mmio_responder #(
   parameter int          WIDTH     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   gpio_mmio_responder_if.slave   bus,
   input  logic [WIDTH-1:0]       gpio_in,
   output logic [WIDTH-1:0]       gpio_out,
   output logic [WIDTH-1:0]       gpio_oe,
   output logic                   gpio_irq
);

   // Register bits at and above WIDTH are held at zero.
   localparam logic [31:0] WMASK = 32'hFFFF_FFFF >> (32 - WIDTH);

   localparam logic [2:0] OFF_OUT  = 3'd0;
   localparam logic [2:0] OFF_DIR  = 3'd1;
   localparam logic [2:0] OFF_IN   = 3'd2;
   localparam logic [2:0] OFF_IE   = 3'd3;
   localparam logic [2:0] OFF_IS   = 3'd4;
   localparam logic [2:0] OFF_POL  = 3'd5;
   localparam logic [2:0] OFF_BOTH = 3'd6;
   localparam logic [2:0] OFF_NONE = 3'd7;

   logic             sel;
   logic             req_rd, req_wr;
   logic [2:0]       req_lt, req_st;
   logic [4:0]       req_a;
   logic [31:0]      req_din;

   logic [31:0]      out_r, dir_r, ie_r, is_r, pol_r, both_r;
   logic [WIDTH-1:0] s1, s2, p;
   logic [1:0]       arm;

   logic [2:0]       off;
   logic [1:0]       lane, sz;
   logic             type_bad, misalign, fault, do_write;
   logic [31:0]      in_w, prev_w, rise, fall, evt;
   logic [31:0]      rd_word, sh, load_val;
   logic [3:0]       be;
   logic [31:0]      bmask, wd, merged, w1c;

   assign sel = (bus.ram_address[31:5] == BASE_ADDR[31:5]);

   // Request stage: only selected accesses are captured, so unselected ones never pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         req_rd  <= 1'b0;
         req_wr  <= 1'b0;
         req_lt  <= 3'd0;
         req_st  <= 3'd0;
         req_a   <= 5'd0;
         req_din <= 32'd0;
      end else begin
         req_rd  <= bus.mem_read_en & sel;
         req_wr  <= bus.mem_write_en & sel;
         req_lt  <= bus.load_type;
         req_st  <= bus.store_type;
         req_a   <= bus.ram_address[4:0];
         req_din <= bus.data_in;
      end
   end

   assign off  = req_a[4:2];
   assign lane = req_a[1:0];

   always_comb begin
      in_w   = '0;
      prev_w = '0;
      in_w[WIDTH-1:0]   = s2;
      prev_w[WIDTH-1:0] = p;
   end

   // Access checks; a simultaneous read and write is always rejected.
   always_comb begin
      type_bad = 1'b0;
      sz       = 2'd0;
      if (req_rd && req_wr) begin
         type_bad = 1'b1;
      end else if (req_rd) begin
         type_bad = (req_lt == 3'b011) || (req_lt == 3'b110) || (req_lt == 3'b111);
         sz       = req_lt[1:0];
      end else if (req_wr) begin
         type_bad = req_st[2] || (req_st[1:0] == 2'b11);
         sz       = req_st[1:0];
      end
      misalign = ((sz == 2'd1) && lane[0]) || ((sz == 2'd2) && (lane != 2'd0));
      fault    = (req_rd || req_wr) &&
                 (type_bad || misalign || (off == OFF_NONE) || (req_wr && (off == OFF_IN)));
      do_write = req_wr && !fault;
   end

   always_comb begin
      rd_word = '0;
      case (off)
         OFF_OUT:  rd_word = out_r;
         OFF_DIR:  rd_word = dir_r;
         OFF_IN:   rd_word = in_w;
         OFF_IE:   rd_word = ie_r;
         OFF_IS:   rd_word = is_r;
         OFF_POL:  rd_word = pol_r;
         OFF_BOTH: rd_word = both_r;
         default:  rd_word = '0;
      endcase
   end

   // Load extraction: bit 2 of funct3 selects zero extension.
   always_comb begin
      sh = rd_word >> {lane, 3'b000};
      case (sz)
         2'd0:    load_val = {{24{~req_lt[2] & sh[7]}}, sh[7:0]};
         2'd1:    load_val = {{16{~req_lt[2] & sh[15]}}, sh[15:0]};
         default: load_val = sh;
      endcase
   end

   // Store lane merge; the same lane mask limits W1C on IS.
   always_comb begin
      case (sz)
         2'd0:    be = 4'b0001 << lane;
         2'd1:    be = 4'b0011 << lane;
         default: be = 4'b1111;
      endcase
      bmask  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      case (sz)
         2'd0:    wd = {4{req_din[7:0]}};
         2'd1:    wd = {2{req_din[15:0]}};
         default: wd = req_din;
      endcase
      merged = ((rd_word & ~bmask) | (wd & bmask)) & WMASK;
      w1c    = (do_write && (off == OFF_IS)) ? (wd & bmask) : 32'd0;
   end

   // Edge events are held off until the arm counter saturates after reset.
   always_comb begin
      rise = in_w & ~prev_w;
      fall = ~in_w & prev_w;
      evt  = (both_r & (rise | fall)) | (~both_r & ((pol_r & rise) | (~pol_r & fall)));
      evt  = (arm == 2'd3) ? (evt & WMASK) : 32'd0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1  <= '0;
         s2  <= '0;
         p   <= '0;
         arm <= 2'd0;
      end else begin
         s1 <= gpio_in;
         s2 <= s1;
         p  <= s2;
         if (arm != 2'd3) arm <= arm + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_r  <= '0;
         dir_r  <= '0;
         ie_r   <= '0;
         is_r   <= '0;
         pol_r  <= '0;
         both_r <= '0;
      end else begin
         if (do_write && (off == OFF_OUT))  out_r  <= merged;
         if (do_write && (off == OFF_DIR))  dir_r  <= merged;
         if (do_write && (off == OFF_IE))   ie_r   <= merged;
         if (do_write && (off == OFF_POL))  pol_r  <= merged;
         if (do_write && (off == OFF_BOTH)) both_r <= merged;
         // Set beats clear when both hit the same bit.
         is_r <= ((is_r & ~w1c) | evt) & WMASK;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.data_out     <= '0;
         bus.data_valid   <= 1'b0;
         bus.access_fault <= 1'b0;
      end else begin
         bus.data_valid   <= req_rd;
         bus.access_fault <= fault;
         if (req_rd) bus.data_out <= fault ? 32'd0 : load_val;
      end
   end

   assign gpio_out = out_r[WIDTH-1:0];
   assign gpio_oe  = dir_r[WIDTH-1:0];
   assign gpio_irq = |(is_r & ie_r);

endmodule

// File: tb/tb_gpio_mmio_responder.sv
// tb/tb_gpio_mmio_responder.sv - self-checking bench for gpio_mmio_responder
module tb_gpio_mmio_responder;
   localparam int          W = 16;
   localparam logic [31:0] B = 32'h1000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] gpio_in = '0;
   logic [W-1:0] gpio_out, gpio_oe;
   logic         gpio_irq;

   gpio_mmio_responder_if bus_if ();

   gpio_mmio_responder #(.WIDTH(W), .BASE_ADDR(B)) dut (
      .clk      (clk),
      .reset    (rst_n),
      .bus      (bus_if.slave),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .gpio_irq (gpio_irq)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   logic        r_valid, r_fault, r_early;
   logic [31:0] r_data;

   // Called at a negedge; returns at the negedge after the response slot.
   task automatic op(input logic rd, input logic wr, input logic [2:0] lt, input logic [2:0] st,
                     input logic [31:0] a, input logic [31:0] d);
      bus_if.mem_read_en  = rd;
      bus_if.mem_write_en = wr;
      bus_if.load_type    = lt;
      bus_if.store_type   = st;
      bus_if.ram_address  = a;
      bus_if.data_in      = d;
      @(negedge clk);
      r_early = bus_if.data_valid | bus_if.access_fault;
      bus_if.mem_read_en  = 1'b0;
      bus_if.mem_write_en = 1'b0;
      @(negedge clk);
      r_valid = bus_if.data_valid;
      r_fault = bus_if.access_fault;
      r_data  = bus_if.data_out;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      op(1'b0, 1'b1, 3'd0, 3'd2, a, d);
   endtask

   task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
      op(1'b1, 1'b0, 3'd2, 3'd0, a, 32'd0);
      chk({name, "_valid"}, {31'd0, r_valid}, 32'd1);
      chk(name, r_data, exp);
   endtask

   // Reference model: byte-oriented view of the register file.
   logic [31:0] m_reg [8];

   task automatic ref_op(input logic rd, input logic wr, input logic [2:0] lt, input logic [2:0] st,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic e_pulse, output logic e_fault, output logic e_valid,
                         output logic [31:0] e_data);
      int          lane, off, size;
      logic        sgn, bad;
      logic [31:0] word, val, mask;
      e_pulse = 1'b0; e_fault = 1'b0; e_valid = 1'b0; e_data = 32'd0;
      if (!(a >= B && a <= B + 32'd31) || (!rd && !wr)) return;
      e_pulse = 1'b1;
      lane = int'(a % 4);
      off  = int'((a - B) / 4);
      if (rd && wr) begin
         e_fault = 1'b1; e_valid = 1'b1; return;
      end
      bad = 1'b0; sgn = 1'b0; size = 4;
      if (rd) begin
         e_valid = 1'b1;
         case (lt)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: bad = 1'b1;
         endcase
         if (bad || (lane % size) != 0 || off == 7) begin
            e_fault = 1'b1; return;
         end
         word = (off == 2) ? {16'd0, gpio_in} : m_reg[off];
         mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
         val  = (word >> (8 * lane)) & mask;
         if (sgn && val[8 * size - 1]) val = val | ~mask;
         e_data = val;
      end else begin
         case (st)
            3'd0: size = 1;
            3'd1: size = 2;
            3'd2: size = 4;
            default: bad = 1'b1;
         endcase
         if (bad || (lane % size) != 0 || off == 7 || off == 2) begin
            e_fault = 1'b1; return;
         end
         for (int i = 0; i < size; i++) begin
            if (off == 4) m_reg[4][8 * (lane + i) +: 8] = m_reg[4][8 * (lane + i) +: 8] & ~d[8 * i +: 8];
            else          m_reg[off][8 * (lane + i) +: 8] = d[8 * i +: 8];
         end
         m_reg[off] = m_reg[off] & 32'h0000_FFFF;
      end
   endtask

   typedef struct {
      logic        rd, wr;
      logic [2:0]  lt, st;
      logic [31:0] a, d;
      logic        e_fault, e_valid;
      logic [31:0] e_data;
      logic [15:0] e_out;
   } vec_t;

   vec_t        vt [$];
   logic [31:0] last_d;

   initial begin
      bus_if.mem_read_en = 1'b0; bus_if.mem_write_en = 1'b0;
      bus_if.load_type = 3'd0; bus_if.store_type = 3'd0;
      bus_if.ram_address = 32'd0; bus_if.data_in = 32'd0;

      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd2, B,          32'h0000_A5A5, 1'b0, 1'b0, 32'd0,         16'hA5A5});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd0, B + 1,      32'h0000_003C, 1'b0, 1'b0, 32'd0,         16'h3CA5});
      vt.push_back('{1'b1, 1'b0, 3'd2, 3'd0, B,          32'd0,         1'b0, 1'b1, 32'h0000_3CA5, 16'h3CA5});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd2, B,          32'h0000_0080, 1'b0, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd0, 3'd0, B,          32'd0,         1'b0, 1'b1, 32'hFFFF_FF80, 16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd4, 3'd0, B,          32'd0,         1'b0, 1'b1, 32'h0000_0080, 16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd1, 3'd0, B + 1,      32'd0,         1'b1, 1'b1, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd1, B + 1,      32'h0000_FFFF, 1'b1, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd2, B + 8,      32'h0000_FFFF, 1'b1, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd2, 3'd0, B + 28,     32'd0,         1'b1, 1'b1, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd3, B,          32'h0000_FFFF, 1'b1, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b1, 1'b1, 3'd2, 3'd2, B,          32'h0000_FFFF, 1'b1, 1'b1, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd2, B + 32,     32'h0000_FFFF, 1'b0, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd2, 32'h2000_0000, 32'h0000_FFFF, 1'b0, 1'b0, 32'd0,      16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd2, 3'd0, B - 4,      32'd0,         1'b0, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd1, B + 6,      32'h0000_BEEF, 1'b0, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b0, 1'b1, 3'd0, 3'd1, B + 4,      32'h0000_8001, 1'b0, 1'b0, 32'd0,         16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd1, 3'd0, B + 4,      32'd0,         1'b0, 1'b1, 32'hFFFF_8001, 16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd5, 3'd0, B + 4,      32'd0,         1'b0, 1'b1, 32'h0000_8001, 16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd2, 3'd0, B + 6,      32'd0,         1'b1, 1'b1, 32'd0,         16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd0, 3'd0, B + 5,      32'd0,         1'b0, 1'b1, 32'hFFFF_FF80, 16'h0080});
      vt.push_back('{1'b1, 1'b0, 3'd2, 3'd0, B,          32'd0,         1'b0, 1'b1, 32'h0000_0080, 16'h0080});

      // Reset with pins high, then hold them: no spurious events.
      gpio_in = 16'hFFFF;
      repeat (3) @(negedge clk);
      chk("rst_data_out", bus_if.data_out, 32'd0);
      chk("rst_valid", {31'd0, bus_if.data_valid}, 32'd0);
      chk("rst_gpio_out", {16'd0, gpio_out}, 32'd0);
      chk("rst_gpio_oe", {16'd0, gpio_oe}, 32'd0);
      chk("rst_irq", {31'd0, gpio_irq}, 32'd0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      rd_chk("is_after_reset", B + 16, 32'd0);
      chk("irq_after_reset", {31'd0, gpio_irq}, 32'd0);
      rd_chk("in_high", B + 8, 32'h0000_FFFF);

      // Falling edges with default POL=0 set every IS bit.
      gpio_in = 16'h0000;
      repeat (5) @(negedge clk);
      rd_chk("is_all_fall", B + 16, 32'h0000_FFFF);
      chk("irq_ie_off", {31'd0, gpio_irq}, 32'd0);
      sw(B + 16, 32'h0000_FFFF);
      rd_chk("is_cleared", B + 16, 32'd0);
      last_d = 32'd0;

      foreach (vt[i]) begin
         op(vt[i].rd, vt[i].wr, vt[i].lt, vt[i].st, vt[i].a, vt[i].d);
         chk($sformatf("row%0d_latency", i), {31'd0, r_early}, 32'd0);
         chk($sformatf("row%0d_fault", i), {31'd0, r_fault}, {31'd0, vt[i].e_fault});
         chk($sformatf("row%0d_valid", i), {31'd0, r_valid}, {31'd0, vt[i].e_valid});
         if (vt[i].e_valid) last_d = vt[i].e_data;
         chk($sformatf("row%0d_data", i), r_data, last_d);
         chk($sformatf("row%0d_gpio_out", i), {16'd0, gpio_out}, {16'd0, vt[i].e_out});
      end
      chk("dir_final", {16'd0, gpio_oe}, 32'h0000_8001);

      // Rising edge on pin 0 -> IS[0] and irq on the third edge.
      sw(B + 12, 32'h1);
      sw(B + 20, 32'h1);
      gpio_in[0] = 1'b1;
      @(negedge clk); chk("irq_edge1", {31'd0, gpio_irq}, 32'd0);
      @(negedge clk); chk("irq_edge2", {31'd0, gpio_irq}, 32'd0);
      @(negedge clk); chk("irq_edge3", {31'd0, gpio_irq}, 32'd1);
      sw(B + 16, 32'h1);
      chk("irq_w1c", {31'd0, gpio_irq}, 32'd0);

      // W1C lands on the same edge as a new event: set wins.
      gpio_in[0] = 1'b0;
      repeat (4) @(negedge clk);
      rd_chk("is_fall_ignored", B + 16, 32'd0);
      gpio_in[0] = 1'b1;
      @(negedge clk);
      bus_if.mem_write_en = 1'b1; bus_if.store_type = 3'd2;
      bus_if.ram_address = B + 16; bus_if.data_in = 32'h1;
      @(negedge clk);
      chk("irq_before_collide", {31'd0, gpio_irq}, 32'd0);
      bus_if.mem_write_en = 1'b0;
      @(negedge clk);
      chk("irq_collide", {31'd0, gpio_irq}, 32'd1);
      rd_chk("is_collide", B + 16, 32'h1);
      sw(B + 16, 32'h1);

      // BOTH on pin 3 catches a fall despite POL[3]=1.
      sw(B + 12, 32'h9);
      sw(B + 20, 32'h9);
      sw(B + 24, 32'h8);
      gpio_in[3] = 1'b1;
      repeat (5) @(negedge clk);
      sw(B + 16, 32'h8);
      rd_chk("is3_cleared", B + 16, 32'd0);
      gpio_in[3] = 1'b0;
      repeat (5) @(negedge clk);
      rd_chk("is3_both_fall", B + 16, 32'h8);
      chk("irq_both", {31'd0, gpio_irq}, 32'd1);
      sw(B + 16, 32'h8);
      sw(B + 24, 32'h0);
      sw(B + 20, 32'h1);
      gpio_in[3] = 1'b1;
      repeat (5) @(negedge clk);
      rd_chk("is3_rise_pol0", B + 16, 32'd0);
      chk("irq_rise_pol0", {31'd0, gpio_irq}, 32'd0);

      // Byte-lane W1C clears only the written lane.
      sw(B + 24, 32'hFFFF);
      gpio_in = gpio_in ^ 16'h0101;
      repeat (5) @(negedge clk);
      rd_chk("is_two_bits", B + 16, 32'h0000_0101);
      op(1'b0, 1'b1, 3'd0, 3'd0, B + 16, 32'h0000_00FF);
      rd_chk("is_sb_lane0", B + 16, 32'h0000_0100);
      op(1'b0, 1'b1, 3'd0, 3'd0, B + 17, 32'h0000_0001);
      rd_chk("is_sb_lane1", B + 16, 32'd0);

      // Reset during an access cancels its response.
      bus_if.mem_read_en = 1'b1; bus_if.load_type = 3'd2; bus_if.ram_address = B;
      @(negedge clk);
      bus_if.mem_read_en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("cancel_valid", {31'd0, bus_if.data_valid}, 32'd0);
      chk("cancel_data", bus_if.data_out, 32'd0);
      gpio_in = W'($urandom);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      for (int k = 0; k < 8; k++) m_reg[k] = 32'd0;

      // Randomized accesses against the reference model; pins stay constant.
      for (int n = 0; n < 300; n++) begin
         logic        rd, wr, ep, ef, ev;
         logic [2:0]  lt, st;
         logic [31:0] a, d, ed;
         int          kind;
         kind = $urandom_range(0, 9);
         rd = (kind <= 4) || (kind == 9);
         wr = (kind >= 5);
         lt = 3'($urandom_range(0, 7));
         st = (kind == 9 || $urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 2));
         a  = ($urandom_range(0, 7) == 0) ? $urandom : B + 32'($urandom_range(0, 31));
         d  = $urandom;
         ref_op(rd, wr, lt, st, a, d, ep, ef, ev, ed);
         op(rd, wr, lt, st, a, d);
         chk($sformatf("rnd%0d_fault", n), {31'd0, r_fault}, {31'd0, ef});
         chk($sformatf("rnd%0d_valid", n), {31'd0, r_valid}, {31'd0, ev});
         if (ev) chk($sformatf("rnd%0d_data", n), r_data, ed);
         if (!ep) chk($sformatf("rnd%0d_nopulse", n), {31'd0, r_valid | r_fault}, 32'd0);
         chk($sformatf("rnd%0d_out", n), {16'd0, gpio_out}, m_reg[0]);
         chk($sformatf("rnd%0d_oe", n), {16'd0, gpio_oe}, m_reg[1]);
         chk($sformatf("rnd%0d_irq", n), {31'd0, gpio_irq}, {31'd0, |(m_reg[3] & m_reg[4])});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/gpio_mmio_responder.md
Name: gpio_mmio_responder

Overview:
Memory-mapped GPIO peripheral that acts as the responder on the CPU load/store bus. It decodes load/store type, byte lanes and addresses, and holds the output, direction and interrupt registers. Input pins pass through a two-flop synchronizer and an edge detector. The block drives a level interrupt; two instances feed the core's gpio0_irq and gpio1_irq inputs.

Parameters:
WIDTH, 16, number of GPIO pins (1..32); register bits at and above WIDTH read 0 and ignore writes.
BASE_ADDR, 32'h1000_0000, 32-byte-aligned base of the register window.

Ports:
clk  input  1  core clock; all flops on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
mem_read_en  input  1  load request this cycle.
mem_write_en  input  1  store request this cycle.
load_type  input  3  RV32 load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
store_type  input  3  RV32 store funct3: 000 SB, 001 SH, 010 SW.
ram_address  input  32  byte address.
data_in  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
data_out  output  32  load result, extended to 32 bits; registered.
data_valid  output  1  one-cycle pulse when data_out is updated.
access_fault  output  1  one-cycle pulse when a selected access is rejected.
gpio_in  input  WIDTH  raw asynchronous pin inputs.
gpio_out  output  WIDTH  pin output values (the OUT register).
gpio_oe  output  WIDTH  pin output enables (the DIR register; 1 = drive).
gpio_irq  output  1  level interrupt, equal to |(IS & IE).

Behaviour:
- Reset (reset=0, asynchronous): all registers, synchronizer flops, the previous-sample flop, data_out, data_valid and access_fault go to 0; the arm counter goes to 0. gpio_irq is therefore 0.
- Select condition: ram_address[31:5] == BASE_ADDR[31:5]. Unselected accesses have no effect and produce no pulse.
- Register map (word offsets):
  - 0x00 OUT: read/write.
  - 0x04 DIR: read/write.
  - 0x08 IN: read-only, the synchronized pin value.
  - 0x0C IE: read/write interrupt enable.
  - 0x10 IS: interrupt status, sticky, write-1-to-clear.
  - 0x14 POL: read/write; 1 = rising edge, 0 = falling edge.
  - 0x18 BOTH: read/write; 1 = both edges, overrides POL.
  - 0x1C: unmapped.
- Byte lane is ram_address[1:0]. SB writes data_in[7:0] into that lane. SH requires addr[0]=0 and writes data_in[15:0] into lanes {addr[1],0}. SW requires addr[1:0]=0. Lanes that are not written are preserved.
- Loads extract the addressed byte or half: LB and LH sign-extend, LBU and LHU zero-extend. The alignment rules match stores. Reads have no side effects, including reads of IS.
- Read latency: a request sampled at edge N updates data_out and pulses data_valid after edge N+1. data_out holds its value until the next read completes.
- Faults raise access_fault in the same cycle slot as data_valid. A faulting access writes nothing, and a faulting read returns data_out=0 with data_valid=1. A selected access faults when any of these holds:
  - the access is misaligned;
  - the offset is 0x1C;
  - the access is a store to IN;
  - mem_read_en and mem_write_en are both high;
  - the type code is reserved (store 011..111; load 011, 110, 111).
- Synchronizer: two flops (s1, s2) produce IN = s2. An edge is computed against the previous sample p: rise = s2&~p, fall = ~s2&p.
- Event per bit = BOTH ? (rise|fall) : (POL ? rise : fall). An event sets the IS bit.
- Arm counter: a 2-bit counter increments after reset and saturates at 3. Events are suppressed while the counter is below 3, so pins that are high at reset do not create spurious events.
- Simultaneous W1C and event on the same IS bit in the same cycle: the set wins and the bit stays 1.
- W1C through SB or SH clears only bits within the written lanes.
- Event latency: a pin change is visible in IN 2 cycles later. The IS bit sets, and gpio_irq rises when IE is set, on the edge after that (3 edges total from a pin change that lands just before a clock edge).
- Reset assertion mid-access cancels the access: no data_valid pulse follows.

Test Plan:
- Reset with gpio_in=16'hFFFF, then hold the pins for 10 cycles -> IS reads 0, gpio_irq=0; IN reads 0x0000FFFF.
- SW 0x0000A5A5 to OUT, then SB 0x3C at offset 0x01 -> gpio_out=16'h3CA5; LW OUT -> data_out=0x00003CA5 with data_valid 1 cycle after the request.
- LB at offset 0x00 with OUT=0x0080 -> data_out=0xFFFFFF80; LBU -> 0x00000080; LH at offset 0x01 -> access_fault=1, data_out=0, OUT unchanged.
- IE=1, POL=1, gpio_in[0] 0->1 -> IS[0]=1 and gpio_irq=1 within 3 edges; SW 0x1 to IS -> gpio_irq=0 next cycle. Repeat with the W1C landing in the same cycle as a new event -> IS[0] stays 1.
- BOTH[3]=1, IE[3]=1, pulse gpio_in[3] 1->0 -> IS[3]=1; POL[3]=0 with BOTH[3]=0 and a rising edge -> IS[3] stays 0.
- Each of these -> access_fault pulse and no register change:
  - SW to IN;
  - access to offset 0x1C;
  - store_type=011;
  - read and write asserted together.
- Access with ram_address outside the window -> no pulse and no change.
